cond_logic: RTL

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_logic.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cond_logic.sv
// Condition-check and flag-register unit for the execute slot.
// Gates PCSrc/RegWrite/MemWrite by the instruction's condition code
// and keeps the architectural {N,Z,C,V} register.
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   in_valid, stall      slot occupancy and hold
//   Cond, ALUFlags       condition field, ALU {N,Z,C,V}
//   FlagW                [1] writes N,Z; [0] writes C,V
//   PCs, RegW, MemW      ungated decoder controls
//   PCSrc, RegWrite,
//   MemWrite             condition-gated controls
//   CondEx               current instruction passes its condition
//   Flags                architectural flag register
//   cond_err             sticky: Cond=1111 seen on a valid instruction
//   exec_count,
//   squash_count         statistics, only with COND_STATS_EN defined
//
// Optional feature macro: COND_STATS_EN (statistics counters).
module cond_logic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCs,
    input  logic             RegW,
    input  logic             MemW,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
`ifdef COND_STATS_EN
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] squash_count,
`endif
    output logic [3:0]       Flags,
    output logic             cond_err
);

    if (CNT_W < 8 || CNT_W > 32) begin : g_cnt_w_range
        $error("cond_logic: CNT_W must be within 8..32");
    end

    logic n_f;
    logic z_f;
    logic c_f;
    logic v_f;
    logic cond_ex;
    logic adv;
    logic upd;

    assign n_f = Flags[3];
    assign z_f = Flags[2];
    assign c_f = Flags[1];
    assign v_f = Flags[0];

    // Evaluated against the registered flags, so a flag write in this
    // cycle is only visible to the next instruction.
    always_comb begin
        cond_ex = 1'b0;
        unique case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b0;
        endcase
    end

    assign CondEx   = cond_ex;

    // Stall does not mask these; the consumer repeats the instruction.
    assign PCSrc    = PCs  & cond_ex & in_valid;
    assign RegWrite = RegW & cond_ex & in_valid;
    assign MemWrite = MemW & cond_ex & in_valid;

    assign adv = in_valid & ~stall;
    assign upd = adv & cond_ex;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Flags <= 4'b0000;
        end else begin
            if (upd & FlagW[1]) begin
                Flags[3:2] <= ALUFlags[3:2];
            end
            if (upd & FlagW[0]) begin
                Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_err <= 1'b0;
        end else if (adv && Cond == 4'b1111) begin
            cond_err <= 1'b1;
        end
    end

`ifdef COND_STATS_EN
    // Saturating counters: stop at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_count   <= '0;
            squash_count <= '0;
        end else if (adv) begin
            if (cond_ex) begin
                if (~&exec_count) begin
                    exec_count <= exec_count + CNT_W'(1);
                end
            end else begin
                if (~&squash_count) begin
                    squash_count <= squash_count + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule
